wt_dcache_rd_client: RTL and testbench
======================================

Name: wt_dcache_rd_client

Overview:
- Single-port load controller: the initiator for one read port of the write-through dcache memory array (rd_req/rd_ack arbitrated port, tag presented one cycle after the grant).
- Accepts one core load at a time.
- Sequences index/offset request, tag compare and hit/miss decision.
- On a miss, issues a request to the miss unit and returns the refill word.
- Sits between the load unit and the dcache memory/miss unit, one instance per read port.

Parameters:
TagWidth, 44, tag bits; paddr = {tag, idx, off}
IdxWidth, 8, cache line index bits
OffWidth, 4, byte offset within line (>=4)
SetAssoc, 8, number of ways
HighPrio, 0, constant value driven on rd_prio_o

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cache_en_i  in  1  0: every load bypasses the array and goes to the miss unit
kill_i  in  1  abort current load; no response is produced
req_valid_i  in  1  load request valid
req_ready_o  out  1  accepts request when high
req_addr_i  in  TagWidth+IdxWidth+OffWidth  physical byte address
req_size_i  in  2  log2 of byte count (0..3)
rsp_valid_o  out  1  one-cycle response pulse, no backpressure
rsp_err_o  out  1  misaligned access; qualifies rsp_valid_o
rsp_data_o  out  64  right-aligned, zero-extended load data
rd_req_o  out  1  array read request
rd_ack_i  in  1  array grant, same cycle as rd_req_o
rd_tag_only_o  out  1  constant 0
rd_prio_o  out  1  constant HighPrio
rd_idx_o  out  IdxWidth  line index
rd_off_o  out  OffWidth  byte offset
rd_tag_o  out  TagWidth  tag; valid in the cycle after the grant
rd_hit_oh_i  in  SetAssoc  one-hot hit vector, cycle after grant
rd_data_i  in  64  selected word, cycle after grant
miss_req_o  out  1  miss request, held until acked
miss_ack_i  in  1  miss unit accepts request
miss_paddr_o  out  TagWidth+IdxWidth+OffWidth  registered address
miss_size_o  out  2  registered size
miss_nc_o  out  1  noncacheable (= ~cache_en sampled at accept)
miss_rtrn_vld_i  in  1  refill word valid, single cycle
miss_rtrn_data_i  in  64  refill 64-bit word containing the address

Behaviour:
Reset:
- All outputs are 0 except req_ready_o=1.
- State IDLE; address/size/nc registers cleared.
- Reset has priority over every event, including mid-miss: the outstanding miss return is not tracked after reset.

States: IDLE, READ, CMP, MISS_REQ, MISS_WAIT, DRAIN, ERR.

- IDLE: req_ready_o=1. On req_valid_i, register addr, size and nc=~cache_en_i.
  - Address misaligned (addr & ((1<<size)-1) != 0): go to ERR.
  - Else if cache_en_i=1: go to READ.
  - Else: go to MISS_REQ.
  - req_ready_o=0 in every other state.
- READ: rd_req_o=1; rd_idx_o/rd_off_o come from registers.
  - rd_ack_i=1: go to CMP.
  - No ack: hold request, stay in READ.
- CMP: rd_tag_o=registered tag.
  - |rd_hit_oh_i: register response from rd_data_i and go to IDLE.
  - Else: go to MISS_REQ.
- MISS_REQ: miss_req_o=1 with stable paddr/size/nc until miss_ack_i; then go to MISS_WAIT.
- MISS_WAIT: on miss_rtrn_vld_i, register response from miss_rtrn_data_i and go to IDLE.
- ERR: rsp_valid_o=1, rsp_err_o=1, rsp_data_o=0 on the next cycle; go to IDLE.

Response formatting:
- Computed on the 64-bit word: shift right by 8*addr[2:0], keep the low 2^size bytes, zero the rest.
- rsp_valid_o/rsp_data_o are registered and appear the cycle after the hit/return cycle.

Latency:
- Hit with immediate grant: accept at T0, rd_req at T1, CMP at T2, rsp_valid at T3.
- Each denied grant cycle adds 1.

kill_i:
- In READ, CMP or ERR: go to IDLE, no response. rd_req_o is still driven in the kill cycle (array side-effect-free).
- In MISS_REQ:
  - With miss_ack_i in the same cycle: go to DRAIN.
  - Otherwise: go to IDLE and drop miss_req_o.
- In MISS_WAIT: go to DRAIN.
- In IDLE: kill_i is ignored.
- kill_i and hit in the same cycle: kill wins, no rsp_valid_o.
- DRAIN: req_ready_o=0; wait for miss_rtrn_vld_i, discard it, go to IDLE. A return arriving in the same cycle as kill_i in MISS_WAIT is discarded and the block goes directly to IDLE.

Other rules:
- A multi-bit rd_hit_oh_i is illegal (assertion); the design takes the OR.
- cache_en_i is sampled only at accept.

Test Plan:
- Hit: cache_en=1, addr=0x0000_1234_0, size=3, rd_ack immediate, rd_hit_oh=0x04, rd_data=0x1122334455667788 -> rd_tag_o valid at T2; rsp_valid at T3, data=0x1122334455667788, err=0.
- Grant stall plus byte extract: addr offset 0x5, size=0, rd_ack low 3 cycles, word 0x1122334455667788 -> rd_req held 4 cycles; rsp_data=0x33 at T6.
- Miss: rd_hit_oh=0, miss_ack after 2 cycles, return 0xAABBCCDD00112233 for addr[2:0]=4, size=2 -> miss_req stable until ack; rsp_data=0xAABBCCDD one cycle after return.
- Bypass plus misaligned: cache_en=0, aligned load -> no rd_req, miss_nc_o=1. Then size=1 at addr[0]=1 -> rsp_valid+rsp_err at T2, no rd_req, no miss_req.
- Kill in MISS_WAIT -> DRAIN, req_ready_o=0. Return arrives -> no rsp_valid; req_ready_o=1 next cycle. Kill coincident with hit -> no response.
- Reset asserted in MISS_REQ -> miss_req_o=0 and req_ready_o=1 next cycle; a new request is then served normally.

Source files
------------

// File: rtl/wt_dcache_rd_client.sv
// Load controller for one read port of the write-through dcache array.
// Accepts a single core load, reads the array, checks the tag and, on a miss
// or when the cache is disabled, fetches the containing word from the miss unit.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | ready for a new load; response of the previous one may be out
// READ      | array read requested, waiting for the port grant
// CMP       | hit vector and data are valid from the array this cycle
// MISS_REQ  | miss request held stable until the miss unit acks it
// MISS_WAIT | waiting for the refill word of our own miss
// DRAIN     | load was killed after the miss was acked; swallow the return
// ERR       | misaligned access, error response goes out next cycle
module wt_dcache_rd_client #(
   parameter int unsigned TagWidth = 44,
   parameter int unsigned IdxWidth = 8,
   parameter int unsigned OffWidth = 4,
   parameter int unsigned SetAssoc = 8,
   parameter bit          HighPrio = 1'b0
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   cache_en_i,
   input  logic                                   kill_i,
   input  logic                                   req_valid_i,
   output logic                                   req_ready_o,
   input  logic [TagWidth+IdxWidth+OffWidth-1:0]  req_addr_i,
   input  logic [1:0]                             req_size_i,
   output logic                                   rsp_valid_o,
   output logic                                   rsp_err_o,
   output logic [63:0]                            rsp_data_o,
   output logic                                   rd_req_o,
   input  logic                                   rd_ack_i,
   output logic                                   rd_tag_only_o,
   output logic                                   rd_prio_o,
   output logic [IdxWidth-1:0]                    rd_idx_o,
   output logic [OffWidth-1:0]                    rd_off_o,
   output logic [TagWidth-1:0]                    rd_tag_o,
   input  logic [SetAssoc-1:0]                    rd_hit_oh_i,
   input  logic [63:0]                            rd_data_i,
   output logic                                   miss_req_o,
   input  logic                                   miss_ack_i,
   output logic [TagWidth+IdxWidth+OffWidth-1:0]  miss_paddr_o,
   output logic [1:0]                             miss_size_o,
   output logic                                   miss_nc_o,
   input  logic                                   miss_rtrn_vld_i,
   input  logic [63:0]                            miss_rtrn_data_i
);

   localparam int unsigned AddrWidth = TagWidth + IdxWidth + OffWidth;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CMP,
      S_MISS_REQ,
      S_MISS_WAIT,
      S_DRAIN,
      S_ERR
   } state_t;

   state_t                 r_state;
   state_t                 w_state_nxt;

   logic [AddrWidth-1:0]   r_paddr;
   logic [1:0]             r_size;
   logic                   r_nc;

   logic                   r_rsp_valid;
   logic                   r_rsp_err;
   logic [63:0]            r_rsp_data;

   logic                   w_accept;
   logic                   w_ld_hit;
   logic                   w_ld_rtrn;
   logic                   w_ld_err;
   logic                   w_misaligned;
   logic                   w_hit;
   logic [63:0]            w_fmt_src;
   logic [63:0]            w_fmt_shift;
   logic [63:0]            w_fmt_data;

   // Any set bit counts as a hit; more than one is flagged by the assertion below.
   assign w_hit = |rd_hit_oh_i;

   // Alignment check on the incoming request (natural alignment to 2^size bytes).
   always_comb begin
      w_misaligned = 1'b0;
      unique case (req_size_i)
         2'd0:    w_misaligned = 1'b0;
         2'd1:    w_misaligned = req_addr_i[0];
         2'd2:    w_misaligned = |req_addr_i[1:0];
         default: w_misaligned = |req_addr_i[2:0];
      endcase
   end

   // State register.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode and the single-cycle load strobes for the datapath.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_ld_hit    = 1'b0;
      w_ld_rtrn   = 1'b0;
      w_ld_err    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (req_valid_i) begin
               w_accept = 1'b1;
               if (w_misaligned) begin
                  w_state_nxt = S_ERR;
               end else if (cache_en_i) begin
                  w_state_nxt = S_READ;
               end else begin
                  w_state_nxt = S_MISS_REQ;
               end
            end
         end
         S_READ: begin
            if (kill_i) begin
               w_state_nxt = S_IDLE;
            end else if (rd_ack_i) begin
               w_state_nxt = S_CMP;
            end
         end
         S_CMP: begin
            if (kill_i) begin
               w_state_nxt = S_IDLE;
            end else if (w_hit) begin
               w_ld_hit    = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_MISS_REQ;
            end
         end
         S_MISS_REQ: begin
            // An acked miss will return a word later, so a kill must drain it.
            if (kill_i) begin
               w_state_nxt = miss_ack_i ? S_DRAIN : S_IDLE;
            end else if (miss_ack_i) begin
               w_state_nxt = S_MISS_WAIT;
            end
         end
         S_MISS_WAIT: begin
            if (kill_i) begin
               w_state_nxt = miss_rtrn_vld_i ? S_IDLE : S_DRAIN;
            end else if (miss_rtrn_vld_i) begin
               w_ld_rtrn   = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (miss_rtrn_vld_i) begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ERR: begin
            w_ld_err    = ~kill_i;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Request registers: captured once at accept and held for the whole load.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_paddr <= '0;
         r_size  <= '0;
         r_nc    <= 1'b0;
      end else if (w_accept) begin
         r_paddr <= req_addr_i;
         r_size  <= req_size_i;
         r_nc    <= ~cache_en_i;
      end
   end

   // Right-align the addressed bytes inside the 64-bit word and zero-extend.
   always_comb begin
      w_fmt_src   = (r_state == S_CMP) ? rd_data_i : miss_rtrn_data_i;
      w_fmt_shift = w_fmt_src >> {r_paddr[2:0], 3'b000};
      w_fmt_data  = '0;
      unique case (r_size)
         2'd0:    w_fmt_data[7:0]  = w_fmt_shift[7:0];
         2'd1:    w_fmt_data[15:0] = w_fmt_shift[15:0];
         2'd2:    w_fmt_data[31:0] = w_fmt_shift[31:0];
         default: w_fmt_data       = w_fmt_shift;
      endcase
   end

   // Response register: one-cycle valid pulse, data held until the next response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= w_ld_hit | w_ld_rtrn | w_ld_err;
         r_rsp_err   <= w_ld_err;
         if (w_ld_hit || w_ld_rtrn) begin
            r_rsp_data <= w_fmt_data;
         end else if (w_ld_err) begin
            r_rsp_data <= '0;
         end
      end
   end

   assign req_ready_o   = (r_state == S_IDLE);
   assign rsp_valid_o   = r_rsp_valid;
   assign rsp_err_o     = r_rsp_err;
   assign rsp_data_o    = r_rsp_data;

   // rd_req stays high through a kill cycle; a read has no side effects on the array.
   assign rd_req_o      = (r_state == S_READ);
   assign rd_tag_only_o = 1'b0;
   assign rd_prio_o     = HighPrio;
   assign rd_idx_o      = r_paddr[OffWidth +: IdxWidth];
   assign rd_off_o      = r_paddr[OffWidth-1:0];
   assign rd_tag_o      = r_paddr[AddrWidth-1 -: TagWidth];

   assign miss_req_o    = (r_state == S_MISS_REQ);
   assign miss_paddr_o  = r_paddr;
   assign miss_size_o   = r_size;
   assign miss_nc_o     = r_nc;

`ifndef SYNTHESIS
   hit_onehot_a: assert property (@(posedge clk_i) disable iff (rst_i)
      (r_state == S_CMP) |-> $onehot0(rd_hit_oh_i));
`endif

endmodule

// File: tb/tb_wt_dcache_rd_client.sv
// Bench for wt_dcache_rd_client: scripted load transactions with random
// addresses, sizes, grant/ack/return delays and kill points. Expected outputs
// come from the transaction script and a plain byte-extract model.
module tb_wt_dcache_rd_client;

   localparam int TW = 44;
   localparam int IW = 8;
   localparam int OW = 4;
   localparam int NW = 8;
   localparam int AW = TW + IW + OW;

   localparam int K_NONE  = 0;
   localparam int K_READ  = 1;
   localparam int K_CMP   = 2;
   localparam int K_MREQ  = 3;
   localparam int K_MWAIT = 4;
   localparam int K_ERR   = 5;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          cache_en_i;
   logic          kill_i;
   logic          req_valid_i;
   logic          req_ready_o;
   logic [AW-1:0] req_addr_i;
   logic [1:0]    req_size_i;
   logic          rsp_valid_o;
   logic          rsp_err_o;
   logic [63:0]   rsp_data_o;
   logic          rd_req_o;
   logic          rd_ack_i;
   logic          rd_tag_only_o;
   logic          rd_prio_o;
   logic [IW-1:0] rd_idx_o;
   logic [OW-1:0] rd_off_o;
   logic [TW-1:0] rd_tag_o;
   logic [NW-1:0] rd_hit_oh_i;
   logic [63:0]   rd_data_i;
   logic          miss_req_o;
   logic          miss_ack_i;
   logic [AW-1:0] miss_paddr_o;
   logic [1:0]    miss_size_o;
   logic          miss_nc_o;
   logic          miss_rtrn_vld_i;
   logic [63:0]   miss_rtrn_data_i;

   always #5 clk_i = ~clk_i;

   wt_dcache_rd_client #(
      .TagWidth(TW), .IdxWidth(IW), .OffWidth(OW), .SetAssoc(NW), .HighPrio(1'b0)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cache_en_i(cache_en_i), .kill_i(kill_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_addr_i(req_addr_i), .req_size_i(req_size_i),
      .rsp_valid_o(rsp_valid_o), .rsp_err_o(rsp_err_o), .rsp_data_o(rsp_data_o),
      .rd_req_o(rd_req_o), .rd_ack_i(rd_ack_i), .rd_tag_only_o(rd_tag_only_o),
      .rd_prio_o(rd_prio_o), .rd_idx_o(rd_idx_o), .rd_off_o(rd_off_o),
      .rd_tag_o(rd_tag_o), .rd_hit_oh_i(rd_hit_oh_i), .rd_data_i(rd_data_i),
      .miss_req_o(miss_req_o), .miss_ack_i(miss_ack_i),
      .miss_paddr_o(miss_paddr_o), .miss_size_o(miss_size_o), .miss_nc_o(miss_nc_o),
      .miss_rtrn_vld_i(miss_rtrn_vld_i), .miss_rtrn_data_i(miss_rtrn_data_i)
   );

   int checks = 0;
   int errors = 0;

   // expectations for the current cycle
   logic          chk_en = 1'b0;
   logic          e_ready, e_rd_req, e_tag, e_miss_req, e_rsp_v, e_rsp_e;
   logic [63:0]   e_rsp_d;
   logic [AW-1:0] e_addr;
   logic [1:0]    e_size;
   logic          e_nc;

   // observations used by the directed literal checks
   int            rsp_cnt = 0;
   int            rd_req_cycles = 0;
   int            miss_req_cycles = 0;
   logic [63:0]   last_rsp_data = '0;
   logic          last_rsp_err = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Byte-extract model: little-endian word, take 2^s bytes starting at byte o.
   function automatic logic [63:0] fmt(input logic [63:0] w, input logic [2:0] o, input logic [1:0] s);
      logic [63:0] sh;
      logic [63:0] m;
      sh = w >> (8 * o);
      m  = (s == 2'd3) ? {64{1'b1}} : ((64'd1 << (8 * (1 << s))) - 64'd1);
      return sh & m;
   endfunction

   // Compare process: every cycle, mid-period.
   always @(negedge clk_i) begin
      if (chk_en) begin
         chk("req_ready", req_ready_o, e_ready);
         chk("rd_req", rd_req_o, e_rd_req);
         chk("miss_req", miss_req_o, e_miss_req);
         chk("rsp_valid", rsp_valid_o, e_rsp_v);
         chk("rd_tag_only", rd_tag_only_o, 64'd0);
         chk("rd_prio", rd_prio_o, 64'd0);
         if (e_rsp_v) begin
            chk("rsp_err", rsp_err_o, e_rsp_e);
            chk("rsp_data", rsp_data_o, e_rsp_d);
         end
         if (e_rd_req) begin
            chk("rd_idx", rd_idx_o, e_addr[OW +: IW]);
            chk("rd_off", rd_off_o, e_addr[OW-1:0]);
         end
         if (e_tag) chk("rd_tag", rd_tag_o, e_addr[AW-1 -: TW]);
         if (e_miss_req) begin
            chk("miss_paddr", miss_paddr_o, e_addr);
            chk("miss_size", miss_size_o, e_size);
            chk("miss_nc", miss_nc_o, e_nc);
         end
      end
      if (rsp_valid_o) begin
         rsp_cnt++;
         last_rsp_data = rsp_data_o;
         last_rsp_err  = rsp_err_o;
      end
      if (rd_req_o) rd_req_cycles++;
      if (miss_req_o) miss_req_cycles++;
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_exp(input logic r, input logic rq, input logic tg, input logic mq,
                          input logic rv, input logic re, input logic [63:0] rd);
      e_ready = r; e_rd_req = rq; e_tag = tg; e_miss_req = mq;
      e_rsp_v = rv; e_rsp_e = re; e_rsp_d = rd;
   endtask

   // Default input values with random noise on don't-care buses.
   task automatic idle_inputs();
      req_valid_i      = 1'b0;
      req_addr_i       = AW'({$urandom, $urandom});
      req_size_i       = 2'($urandom);
      cache_en_i       = 1'($urandom);
      kill_i           = 1'b0;
      rd_ack_i         = 1'b0;
      rd_hit_oh_i      = NW'($urandom);
      rd_data_i        = {$urandom, $urandom};
      miss_ack_i       = 1'b0;
      miss_rtrn_vld_i  = 1'b0;
      miss_rtrn_data_i = {$urandom, $urandom};
   endtask

   task automatic end_idle();
      idle_inputs();
      set_exp(1, 0, 0, 0, 0, 0, '0);
      cyc();
   endtask

   task automatic end_rsp(input logic err, input logic [63:0] d);
      idle_inputs();
      set_exp(1, 0, 0, 0, 1, err, d);
      cyc();
   endtask

   task automatic drain(input int d);
      for (int k = 0; k <= d; k++) begin
         idle_inputs();
         miss_rtrn_vld_i = (k == d);
         set_exp(0, 0, 0, 0, 0, 0, '0);
         cyc();
      end
      end_idle();
   endtask

   // One complete load, from accept to the cycle where the block is idle again.
   task automatic run_txn(input logic [AW-1:0] addr, input logic [1:0] sz, input logic cen,
                          input int gnt_dly, input logic hit, input int ack_dly, input int rtn_dly,
                          input int kill_mode, input int kill_pos, input int drain_dly,
                          input logic [63:0] word);
      logic misal;
      logic [63:0] exp_d;
      case (sz)
         2'd0:    misal = 1'b0;
         2'd1:    misal = addr[0];
         2'd2:    misal = (addr[1:0] != 2'd0);
         default: misal = (addr[2:0] != 3'd0);
      endcase
      exp_d  = fmt(word, addr[2:0], sz);
      e_addr = addr; e_size = sz; e_nc = ~cen;

      idle_inputs();
      req_valid_i = 1'b1; req_addr_i = addr; req_size_i = sz; cache_en_i = cen;
      kill_i = 1'($urandom);
      set_exp(1, 0, 0, 0, 0, 0, '0);
      cyc();

      if (misal) begin
         idle_inputs();
         set_exp(0, 0, 0, 0, 0, 0, '0);
         if (kill_mode == K_ERR) begin
            kill_i = 1'b1;
            cyc();
            end_idle();
            return;
         end
         cyc();
         end_rsp(1'b1, '0);
         return;
      end

      if (cen) begin
         for (int k = 0; k <= gnt_dly; k++) begin
            idle_inputs();
            rd_ack_i = (k == gnt_dly);
            set_exp(0, 1, 0, 0, 0, 0, '0);
            if (kill_mode == K_READ && kill_pos == k) begin
               kill_i = 1'b1;
               cyc();
               end_idle();
               return;
            end
            cyc();
         end
         idle_inputs();
         rd_data_i   = word;
         rd_hit_oh_i = hit ? NW'(1 << $urandom_range(0, NW-1)) : '0;
         set_exp(0, 0, 1, 0, 0, 0, '0);
         if (kill_mode == K_CMP) begin
            kill_i = 1'b1;
            cyc();
            end_idle();
            return;
         end
         cyc();
         if (hit) begin
            end_rsp(1'b0, exp_d);
            return;
         end
      end

      for (int k = 0; k <= ack_dly; k++) begin
         idle_inputs();
         miss_ack_i = (k == ack_dly);
         set_exp(0, 0, 0, 1, 0, 0, '0);
         if (kill_mode == K_MREQ && kill_pos == k) begin
            kill_i = 1'b1;
            cyc();
            if (k == ack_dly) drain(drain_dly);
            else end_idle();
            return;
         end
         cyc();
      end

      for (int k = 0; k <= rtn_dly; k++) begin
         idle_inputs();
         miss_rtrn_vld_i  = (k == rtn_dly);
         miss_rtrn_data_i = word;
         set_exp(0, 0, 0, 0, 0, 0, '0);
         if (kill_mode == K_MWAIT && kill_pos == k) begin
            kill_i = 1'b1;
            cyc();
            if (k == rtn_dly) end_idle();
            else drain(drain_dly);
            return;
         end
         cyc();
      end
      end_rsp(1'b0, exp_d);
   endtask

   int            c0, r0, m0;
   logic [63:0]   r64;
   logic [AW-1:0] ra;
   logic [1:0]    rs;
   int            km;

   initial begin
      rst_i = 1'b1;
      idle_inputs();
      set_exp(1, 0, 0, 0, 0, 0, '0);

      // model pinning
      chk("model_b5", fmt(64'h1122334455667788, 3'd5, 2'd0), 64'h33);
      chk("model_w4", fmt(64'hAABBCCDD00112233, 3'd4, 2'd2), 64'hAABBCCDD);
      chk("model_h2", fmt(64'h1122334455667788, 3'd2, 2'd1), 64'h5566);

      cyc();
      cyc();
      chk("rst_ready", req_ready_o, 64'd1);
      chk("rst_rsp_valid", rsp_valid_o, 64'd0);
      chk("rst_rsp_err", rsp_err_o, 64'd0);
      chk("rst_rsp_data", rsp_data_o, 64'd0);
      chk("rst_rd_req", rd_req_o, 64'd0);
      chk("rst_rd_idx", rd_idx_o, 64'd0);
      chk("rst_rd_off", rd_off_o, 64'd0);
      chk("rst_rd_tag", rd_tag_o, 64'd0);
      chk("rst_miss_req", miss_req_o, 64'd0);
      chk("rst_miss_paddr", miss_paddr_o, 64'd0);
      chk("rst_miss_size", miss_size_o, 64'd0);
      chk("rst_miss_nc", miss_nc_o, 64'd0);
      rst_i = 1'b0;
      chk_en = 1'b1;
      end_idle();

      // hit, immediate grant
      c0 = rsp_cnt; r0 = rd_req_cycles;
      run_txn(56'h12340, 2'd3, 1'b1, 0, 1'b1, 0, 0, K_NONE, 0, 0, 64'h1122334455667788);
      chk("hit_rsp_cnt", 64'(rsp_cnt - c0), 64'd1);
      chk("hit_rd_req_cycles", 64'(rd_req_cycles - r0), 64'd1);
      chk("hit_data", last_rsp_data, 64'h1122334455667788);

      // grant stall plus byte extract
      c0 = rsp_cnt; r0 = rd_req_cycles;
      run_txn(56'h12345, 2'd0, 1'b1, 3, 1'b1, 0, 0, K_NONE, 0, 0, 64'h1122334455667788);
      chk("stall_rd_req_cycles", 64'(rd_req_cycles - r0), 64'd4);
      chk("stall_data", last_rsp_data, 64'h33);

      // miss through the array
      c0 = rsp_cnt; m0 = miss_req_cycles;
      run_txn(56'h56784, 2'd2, 1'b1, 0, 1'b0, 2, 3, K_NONE, 0, 0, 64'hAABBCCDD00112233);
      chk("miss_req_cycles", 64'(miss_req_cycles - m0), 64'd3);
      chk("miss_data", last_rsp_data, 64'hAABBCCDD);

      // bypass, then misaligned
      c0 = rsp_cnt; r0 = rd_req_cycles;
      run_txn(56'h9a8, 2'd3, 1'b0, 0, 1'b0, 1, 1, K_NONE, 0, 0, 64'h0123456789abcdef);
      chk("bypass_rd_req_cycles", 64'(rd_req_cycles - r0), 64'd0);
      chk("bypass_data", last_rsp_data, 64'h0123456789abcdef);
      c0 = rsp_cnt; r0 = rd_req_cycles; m0 = miss_req_cycles;
      run_txn(56'h9a9, 2'd1, 1'b1, 0, 1'b0, 0, 0, K_NONE, 0, 0, 64'h0);
      chk("misal_rsp_cnt", 64'(rsp_cnt - c0), 64'd1);
      chk("misal_err", last_rsp_err, 64'd1);
      chk("misal_no_rd_req", 64'(rd_req_cycles - r0), 64'd0);
      chk("misal_no_miss_req", 64'(miss_req_cycles - m0), 64'd0);

      // kill in MISS_WAIT drains, kill with hit suppresses the response
      c0 = rsp_cnt;
      run_txn(56'h4440, 2'd3, 1'b1, 0, 1'b0, 0, 3, K_MWAIT, 1, 2, 64'h55);
      chk("kill_wait_no_rsp", 64'(rsp_cnt - c0), 64'd0);
      c0 = rsp_cnt;
      run_txn(56'h4448, 2'd3, 1'b1, 1, 1'b1, 0, 0, K_CMP, 0, 0, 64'h66);
      chk("kill_hit_no_rsp", 64'(rsp_cnt - c0), 64'd0);

      // reset while in MISS_REQ
      idle_inputs();
      e_addr = 56'h7770; e_size = 2'd3; e_nc = 1'b1;
      req_valid_i = 1'b1; req_addr_i = 56'h7770; req_size_i = 2'd3; cache_en_i = 1'b0;
      set_exp(1, 0, 0, 0, 0, 0, '0);
      cyc();
      idle_inputs();
      rst_i = 1'b1;
      set_exp(0, 0, 0, 1, 0, 0, '0);
      cyc();
      rst_i = 1'b0;
      chk("rst_mid_paddr", miss_paddr_o, 64'd0);
      end_idle();
      c0 = rsp_cnt;
      run_txn(56'h12340, 2'd3, 1'b1, 0, 1'b1, 0, 0, K_NONE, 0, 0, 64'hfeedfacecafebeef);
      chk("post_rst_data", last_rsp_data, 64'hfeedfacecafebeef);
      chk("post_rst_rsp_cnt", 64'(rsp_cnt - c0), 64'd1);

      // randomized loads
      for (int n = 0; n < 300; n++) begin
         r64 = {$urandom, $urandom};
         ra  = AW'(r64);
         rs  = 2'($urandom);
         if ($urandom_range(0, 4) != 0) begin
            case (rs)
               2'd1:    ra[0]   = 1'b0;
               2'd2:    ra[1:0] = 2'd0;
               2'd3:    ra[2:0] = 3'd0;
               default: ra[0]   = ra[0];
            endcase
         end
         km = ($urandom_range(0, 9) < 5) ? K_NONE : int'($urandom_range(1, 5));
         run_txn(ra, rs, 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), km,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), {$urandom, $urandom});
      end

      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
